sha3_pad_packer: RTL and testbench

Streaming front-end for the `keccak` core: accepts a message as a byte stream of configurable width, packs it into R-bit rate blocks, and applies SHA3 or SHAKE multi-rate padding in hardware. It sits between a byte source (DMA, UART, or a file-reading bench) and the core's `message` input, so padding no longer lives in bench code. It generalises the fixed 1-byte packing to W-byte input beats, any standard capacity, and runtime SHA3/SHAKE domain selection, with full valid/ready backpressure.

---
 rtl/sha3_pad_packer.sv | 176 +++++++++++++++++
 tb/tb_sha3_pad_packer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_pad_packer.sv
// Packs a W-byte beat stream into R-bit rate blocks and applies SHA3/SHAKE multi-rate padding.
// Optional feature macro: SHA3_PAD_SHAKE_EN enables the runtime SHAKE domain (in_shake).
module sha3_pad_packer #(
    parameter int D = 256,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8*W-1:0]         in_data,
    input  logic [$clog2(W+1)-1:0] in_bytes,
    input  logic                   in_last,
    input  logic                   in_shake,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [1600-2*D-1:0]    block_data,
    output logic                   block_last,
    output logic                   block_valid,
    input  logic                   block_ready
);
    localparam int R  = 1600 - 2 * D;
    localparam int NB = R / 8;
    localparam int PW = $clog2(NB + 1);
    localparam int BW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'b00,
        ST_PAD  = 2'b01,
        ST_OUT  = 2'b10
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   ptr_r, ptr_s, ptr_sum_s;
    logic [R-1:0]    blk_r, blk_s;
    logic            pad_pending_r, pad_pending_s;
    logic            block_last_r, block_last_s;
    logic            block_valid_r;
    logic            in_ready_r;
    logic [BW-1:0]   nbytes_s;
    logic [7:0]      dom_s;

`ifdef SHA3_PAD_SHAKE_EN
    logic            shake_r, shake_s;
    logic            first_r, first_s;

    function automatic logic [7:0] domain_byte(input logic shake);
        logic [7:0] d;
        if (shake) begin
            d = 8'hF8;
        end else begin
            d = 8'h60;
        end
        return d;
    endfunction
`else
    logic            unused_shake_s;
    assign unused_shake_s = in_shake;
`endif

    // Next-state, buffer update and padding logic
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        blk_s         = blk_r;
        pad_pending_s = pad_pending_r;
        block_last_s  = block_last_r;
`ifdef SHA3_PAD_SHAKE_EN
        shake_s       = shake_r;
        first_s       = first_r;
        dom_s         = domain_byte(shake_r);
`else
        dom_s         = 8'h60;
`endif
        // in_bytes only matters on the last beat; oversize counts clamp to a full beat
        if (in_last && (in_bytes < BW'(W))) begin
            nbytes_s = in_bytes;
        end else begin
            nbytes_s = BW'(W);
        end
        ptr_sum_s = ptr_r + PW'(nbytes_s);

        case (state_r)
            ST_FILL: begin
                if (in_valid) begin
                    for (int k = 0; k < W; k++) begin
                        blk_s[R-1-8*(int'(ptr_r)+k) -: 8] = (BW'(k) < nbytes_s) ?
                            in_data[8*W-1-8*k -: 8] : blk_r[R-1-8*(int'(ptr_r)+k) -: 8];
                    end
                    ptr_s = ptr_sum_s;
`ifdef SHA3_PAD_SHAKE_EN
                    if (first_r) begin
                        shake_s = in_shake;
                    end else begin
                        shake_s = shake_r;
                    end
                    first_s = in_last;
`endif
                    if (ptr_sum_s == PW'(NB)) begin
                        state_s       = ST_OUT;
                        block_last_s  = 1'b0;
                        pad_pending_s = in_last;
                    end else if (in_last) begin
                        state_s = ST_PAD;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_PAD: begin
                // Domain byte first, then the closing bit so a single pad byte merges both
                blk_s[R-1-8*int'(ptr_r) -: 8] = dom_s;
                blk_s[7:0]   = blk_s[7:0] | 8'h01;
                state_s      = ST_OUT;
                block_last_s = 1'b1;
            end
            ST_OUT: begin
                if (block_ready) begin
                    blk_s        = {R{1'b0}};
                    ptr_s        = {PW{1'b0}};
                    block_last_s = 1'b0;
                    if (pad_pending_r) begin
                        state_s       = ST_PAD;
                        pad_pending_s = 1'b0;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s       = ST_FILL;
                ptr_s         = {PW{1'b0}};
                blk_s         = {R{1'b0}};
                pad_pending_s = 1'b0;
                block_last_s  = 1'b0;
            end
        endcase
    end

    // State, buffer and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_FILL;
            ptr_r         <= {PW{1'b0}};
            blk_r         <= {R{1'b0}};
            pad_pending_r <= 1'b0;
            block_last_r  <= 1'b0;
            block_valid_r <= 1'b0;
            in_ready_r    <= 1'b1;
`ifdef SHA3_PAD_SHAKE_EN
            shake_r       <= 1'b0;
            first_r       <= 1'b1;
`endif
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            blk_r         <= blk_s;
            pad_pending_r <= pad_pending_s;
            block_last_r  <= block_last_s;
            block_valid_r <= (state_s == ST_OUT);
            in_ready_r    <= (state_s == ST_FILL);
`ifdef SHA3_PAD_SHAKE_EN
            shake_r       <= shake_s;
            first_r       <= first_s;
`endif
        end
    end

    assign in_ready    = in_ready_r;
    assign block_data  = blk_r;
    assign block_last  = block_last_r;
    assign block_valid = block_valid_r;

endmodule

// File: tb/tb_sha3_pad_packer.sv
// Self-checking bench for sha3_pad_packer (D=256, W=8): random messages against a
// byte-queue padding model, with handshake timing, hold-under-backpressure and reset checks.
module tb_sha3_pad_packer;
    localparam int D  = 256;
    localparam int W  = 8;
    localparam int R  = 1600 - 2 * D;
    localparam int NB = R / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [8*W-1:0] in_data;
    logic [3:0]    in_bytes;
    logic          in_last, in_shake, in_valid, in_ready;
    logic [R-1:0]  block_data;
    logic          block_last, block_valid, block_ready;

    int checks = 0;
    int errors = 0;

    sha3_pad_packer #(.D(D), .W(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_bytes(in_bytes),
        .in_last(in_last), .in_shake(in_shake), .in_valid(in_valid), .in_ready(in_ready),
        .block_data(block_data), .block_last(block_last), .block_valid(block_valid),
        .block_ready(block_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dom_byte(input bit shake);
`ifdef SHA3_PAD_SHAKE_EN
        return shake ? 8'hF8 : 8'h60;
`else
        return 8'h60;
`endif
    endfunction

    // Send one message and check every resulting block against the padding model
    task automatic run_msg(input string name, input logic [7:0] msg[$], input bit shake,
                           input int bp, input bit empty_last, input int gap_pct);
        logic [7:0]   pq[$];
        logic [R-1:0] exp_blk[$];
        logic [R-1:0] eb, prev_data;
        int len, nbeats, lastn, nblk, bi, bk, cyc, hold, mptr, n, fj;
        int exp1[$];
        int exp0[$];
        bit prev_pend, prev_last, ir_chk, ir_exp, hs_in, hs_out, lastb, want_last;
        len = msg.size();
        pq = msg;
        pq.push_back(dom_byte(shake));
        while (pq.size() % NB != 0) pq.push_back(8'h00);
        pq[pq.size()-1] = pq[pq.size()-1] | 8'h01;
        nblk = pq.size() / NB;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < NB; j++) eb[R-1-8*j -: 8] = pq[b*NB+j];
            exp_blk.push_back(eb);
        end
        if ((len % W != 0) || (len == 0) || empty_last) begin
            nbeats = len / W + 1;
            lastn  = len % W;
        end else begin
            nbeats = len / W;
            lastn  = W;
        end
        bi = 0; bk = 0; cyc = 0; hold = 0; mptr = 0;
        prev_pend = 1'b0; prev_last = 1'b0; ir_chk = 1'b0; ir_exp = 1'b0;
        while ((bk < nblk) && (cyc < 4000)) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (in_ready && block_valid) begin
                errors++;
                $display("FAIL %s excl: in_ready=%b block_valid=%b, want not both 1", name, in_ready, block_valid);
            end
            if (prev_pend) begin
                checks++;
                if ((block_valid !== 1'b1) || (block_data !== prev_data) || (block_last !== prev_last)) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b last=%b data_same=%b, want 1 %b 1", name,
                             block_valid, block_last, block_data === prev_data, prev_last);
                end
            end
            if (ir_chk) begin
                checks++;
                if (in_ready !== ir_exp) begin
                    errors++;
                    $display("FAIL %s ready_after_out: got %b want %b", name, in_ready, ir_exp);
                end
                ir_chk = 1'b0;
            end
            while ((exp1.size() > 0) && (exp1[0] == cyc)) begin
                checks++;
                if (block_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s valid_latency: got %b want 1 at cycle %0d", name, block_valid, cyc);
                end
                exp1.delete(0);
            end
            while ((exp0.size() > 0) && (exp0[0] == cyc)) begin
                checks++;
                if (block_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pad_cycle: got valid=%b want 0 at cycle %0d", name, block_valid, cyc);
                end
                exp0.delete(0);
            end
            lastb = (bi == nbeats - 1);
            n = lastb ? lastn : W;
            if ((bi < nbeats) && ($urandom_range(99) >= gap_pct)) begin
                in_valid = 1'b1;
                in_last  = lastb;
                for (int k = 0; k < W; k++) begin
                    if (k < n) in_data[8*W-1-8*k -: 8] = msg[bi*W+k];
                    else       in_data[8*W-1-8*k -: 8] = 8'($urandom);
                end
                if (lastb && (n == W)) in_bytes = 4'(W + $urandom_range(7));
                else if (lastb)        in_bytes = 4'(n);
                else                   in_bytes = 4'($urandom);
                in_shake = (bi == 0) ? shake : 1'($urandom);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
                in_data  = {$urandom, $urandom};
                in_shake = 1'($urandom);
            end
            if (bp < 0) block_ready = 1'($urandom);
            else        block_ready = (hold >= bp);
            hs_in  = in_valid && in_ready;
            hs_out = block_valid && block_ready;
            if (hs_out) begin
                eb = exp_blk[bk];
                checks++;
                if (block_data !== eb) begin
                    fj = 0;
                    for (int j = NB - 1; j >= 0; j--)
                        if (block_data[R-1-8*j -: 8] !== eb[R-1-8*j -: 8]) fj = j;
                    errors++;
                    $display("FAIL %s data blk%0d byte%0d: got %h want %h", name, bk, fj,
                             block_data[R-1-8*fj -: 8], eb[R-1-8*fj -: 8]);
                end
                want_last = (bk == nblk - 1);
                checks++;
                if (block_last !== want_last) begin
                    errors++;
                    $display("FAIL %s last blk%0d: got %b want %b", name, bk, block_last, want_last);
                end
                bk++;
                hold = 0;
                ir_chk = 1'b1;
                ir_exp = (bi < nbeats) || (bk == nblk);
                prev_pend = 1'b0;
            end else begin
                if (block_valid) hold++;
                prev_pend = block_valid;
                prev_data = block_data;
                prev_last = block_last;
            end
            if (hs_in) begin
                bi++;
                mptr += n;
                if (mptr == NB) begin
                    exp1.push_back(cyc + 1);
                    mptr = 0;
                end else if (lastb) begin
                    exp0.push_back(cyc + 1);
                    exp1.push_back(cyc + 2);
                end
            end
        end
        if (bk < nblk) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d blocks want %0d", name, bk, nblk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        block_ready = 1'b0;
        if (ir_chk) begin
            checks++;
            if ((in_ready !== 1'b1) || (block_valid !== 1'b0)) begin
                errors++;
                $display("FAIL %s idle_after: in_ready=%b valid=%b want 1 0", name, in_ready, block_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_shake = 1'b0;
        in_data = {2{32'h0}}; in_bytes = 4'h0; block_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ((block_valid !== 1'b0) || (block_last !== 1'b0)) begin
            errors++;
            $display("FAIL reset_flags: valid=%b last=%b want 0 0", block_valid, block_last);
        end
        checks++;
        if (block_data !== {R{1'b0}}) begin
            errors++;
            $display("FAIL reset_data: got nonzero want 0");
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ((in_ready !== 1'b1) || (block_valid !== 1'b0)) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b valid=%b want 1 0", in_ready, block_valid);
        end
    endtask

    task automatic test_empty();
        logic [7:0] m[$];
        run_msg("empty_sha3", m, 1'b0, 0, 1'b1, 0);
    endtask

    task automatic test_135_136();
        logic [7:0] m[$];
        for (int i = 0; i < 135; i++) m.push_back(8'($urandom));
        run_msg("len135", m, 1'b0, 0, 1'b0, 0);
        m.push_back(8'($urandom));
        run_msg("len136_full_last", m, 1'b0, 0, 1'b0, 0);
        run_msg("len136_empty_last", m, 1'b0, 0, 1'b1, 0);
    endtask

    task automatic test_shake();
        logic [7:0] m[$];
        m.push_back(8'hAB); m.push_back(8'hCD); m.push_back(8'hEF);
        run_msg("shake3", m, 1'b1, 0, 1'b0, 0);
        run_msg("sha3_3", m, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        logic [7:0] m[$];
        for (int i = 0; i < 150; i++) m.push_back(8'($urandom));
        run_msg("backpressure5", m, 1'b1, 5, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] m[$];
        in_last = 1'b0; block_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = {$urandom, $urandom}; in_bytes = 4'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ((block_valid !== 1'b0) || (block_last !== 1'b0) || (block_data !== {R{1'b0}})) begin
            errors++;
            $display("FAIL reset_mid_fill: valid=%b last=%b data_zero=%b want 0 0 1",
                     block_valid, block_last, block_data === {R{1'b0}});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < NB / W; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = {$urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (block_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_outfill: valid=%b want 1", block_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ((block_valid !== 1'b0) || (block_data !== {R{1'b0}})) begin
            errors++;
            $display("FAIL reset_mid_out: valid=%b data_zero=%b want 0 1", block_valid, block_data === {R{1'b0}});
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_msg("empty_after_reset", m, 1'b0, 0, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [7:0] m[$];
        int len, sel, bp;
        for (int it = 0; it < 14; it++) begin
            m.delete();
            sel = $urandom_range(5);
            case (sel)
                0: len = 135;
                1: len = 272;
                2: len = 271;
                default: len = $urandom_range(300);
            endcase
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            sel = $urandom_range(2);
            bp = (sel == 0) ? -1 : ((sel == 1) ? 0 : 3);
            run_msg($sformatf("random%0d_len%0d", it, len), m, 1'($urandom), bp,
                    1'($urandom), ($urandom_range(1) == 1) ? 30 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_135_136();
        test_shake();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
